alu_result_buffer: RTL and testbench

- Issue-side counterpart of the combinational ALU.
- Accepts issued ALU instructions through a valid/ready handshake, presents each operand bundle to the ALU and captures the ALU result and branch outcome in the same cycle.
- Buffers captured results in a DEPTH-entry FIFO tagged with trans_id and returns them to writeback through a valid/ready handshake.
- Decouples ALU timing from writeback back-pressure; supports flush on mispredict or exception.

---
 rtl/alu_result_buffer.sv | 177 +++++++++++++++++
 tb/tb_alu_result_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// ALU result buffer: drives issued operand bundles into the combinational ALU,
// captures the result and branch outcome in the same cycle, and queues them in a
// small FIFO so that writeback back-pressure never stalls the ALU itself.

package alu_result_buffer_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    // ALU operation encoding; ADD is zero so an all-zero bundle is a quiet ALU op
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_EQ  = 4'd2,
        ALU_NE  = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6
    } fu_op_t;

    typedef struct packed {
        fu_op_t                   operation;
        logic [XLEN-1:0]          operand_a;
        logic [XLEN-1:0]          operand_b;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

endpackage

// Protocol checker: an op refused by the buffer must be held stable by upstream
module alu_result_buffer_chk #(
    parameter int unsigned W = 8
) (
    input logic         clk_i,
    input logic         rst_i,
    input logic         flush_i,
    input logic         issue_valid_i,
    input logic         issue_ready_o,
    input logic [W-1:0] issue_data_i
);

    // Refused op must not change before the next edge
    a_issue_hold: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        (issue_valid_i && !issue_ready_o) |=> $stable(issue_data_i));

endmodule

module alu_result_buffer #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned DEPTH         = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             issue_valid_i,
    output logic                             issue_ready_o,
    input  alu_result_buffer_pkg::fu_data_t  issue_fu_data_i,
    output alu_result_buffer_pkg::fu_data_t  alu_fu_data_o,
    input  logic [XLEN-1:0]                  alu_result_i,
    input  logic                             alu_branch_res_i,
    output logic                             wb_valid_o,
    input  logic                             wb_ready_i,
    output logic [XLEN-1:0]                  wb_result_o,
    output logic                             wb_branch_res_o,
    output logic [TRANS_ID_BITS-1:0]         wb_trans_id_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic [CNT_W-1:0]         w_count_nxt;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_wb_valid;

    logic [XLEN-1:0]          r_res_mem [DEPTH];
    logic                     r_br_mem  [DEPTH];
    logic [TRANS_ID_BITS-1:0] r_id_mem  [DEPTH];

    // Pointer advance with explicit wrap from DEPTH-1 back to entry 0
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Handshake qualification; a flush cycle suppresses both push and pop
    always_comb begin
        w_wb_valid    = (r_count != '0);
        issue_ready_o = (r_count < CNT_W'(DEPTH)) | (w_wb_valid & wb_ready_i);
        w_push        = issue_valid_i & issue_ready_o & ~flush_i;
        w_pop         = w_wb_valid & wb_ready_i & ~flush_i;
    end

    // Occupancy update: simultaneous push and pop leaves the count unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and count registers; reset takes priority over flush
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
        end
    end

    // Entry storage captures the ALU return in the issue cycle; not reset
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_res_mem[r_wr_ptr] <= alu_result_i;
            r_br_mem[r_wr_ptr]  <= alu_branch_res_i;
            r_id_mem[r_wr_ptr]  <= issue_fu_data_i.trans_id;
        end
    end

    // ALU sees the issued bundle only while valid, otherwise a quiet ADD of zeros
    always_comb begin
        if (issue_valid_i) begin
            alu_fu_data_o = issue_fu_data_i;
        end else begin
            alu_fu_data_o = '0;
        end
    end

    // Writeback head view; forced to zero while the FIFO is empty
    always_comb begin
        wb_valid_o = w_wb_valid;
        count_o    = r_count;
        if (w_wb_valid) begin
            wb_result_o     = r_res_mem[r_rd_ptr];
            wb_branch_res_o = r_br_mem[r_rd_ptr];
            wb_trans_id_o   = r_id_mem[r_rd_ptr];
        end else begin
            wb_result_o     = '0;
            wb_branch_res_o = 1'b0;
            wb_trans_id_o   = '0;
        end
    end

    alu_result_buffer_chk #(
        .W ($bits(alu_result_buffer_pkg::fu_data_t))
    ) u_chk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_data_i  (issue_fu_data_i)
    );

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios followed by a
// randomized stream, all compared against a queue-based reference model.
module tb_alu_result_buffer;
    import alu_result_buffer_pkg::*;

    localparam int DEPTH = 2;

    logic            clk_i;
    logic            rst_i;
    logic            flush_i;
    logic            issue_valid_i;
    logic            issue_ready_o;
    fu_data_t        issue_fu_data_i;
    fu_data_t        alu_fu_data_o;
    logic [63:0]     alu_result_i;
    logic            alu_branch_res_i;
    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [63:0]     wb_result_o;
    logic            wb_branch_res_o;
    logic [2:0]      wb_trans_id_o;
    logic [1:0]      count_o;

    typedef struct packed {
        logic [63:0] res;
        logic        br;
        logic [2:0]  id;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    logic  acc;

    alu_result_buffer #(.XLEN(64), .TRANS_ID_BITS(3), .DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_fu_data_i  (issue_fu_data_i),
        .alu_fu_data_o    (alu_fu_data_o),
        .alu_result_i     (alu_result_i),
        .alu_branch_res_i (alu_branch_res_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_result_o      (wb_result_o),
        .wb_branch_res_o  (wb_branch_res_o),
        .wb_trans_id_o    (wb_trans_id_o),
        .count_o          (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference ALU semantics
    function automatic exp_t ref_alu(input fu_data_t d);
        exp_t e;
        e.id = d.trans_id;
        e.br = 1'b0;
        case (d.operation)
            ALU_ADD: e.res = d.operand_a + d.operand_b;
            ALU_SUB: e.res = d.operand_a - d.operand_b;
            ALU_EQ:  begin e.br = (d.operand_a == d.operand_b); e.res = {63'd0, e.br}; end
            ALU_NE:  begin e.br = (d.operand_a != d.operand_b); e.res = {63'd0, e.br}; end
            ALU_AND: e.res = d.operand_a & d.operand_b;
            ALU_OR:  e.res = d.operand_a | d.operand_b;
            ALU_XOR: e.res = d.operand_a ^ d.operand_b;
            default: e.res = 64'd0;
        endcase
        return e;
    endfunction

    // Combinational ALU stub feeding the buffer
    always_comb begin
        exp_t a;
        a = ref_alu(alu_fu_data_o);
        alu_result_i     = a.res;
        alu_branch_res_i = a.br;
    end

    function automatic fu_data_t mk(input fu_op_t op, input logic [63:0] a,
                                    input logic [63:0] b, input logic [2:0] id);
        fu_data_t d;
        d.operation = op;
        d.operand_a = a;
        d.operand_b = b;
        d.trans_id  = id;
        return d;
    endfunction

    function automatic fu_data_t rnd_op(input logic [2:0] id);
        logic [63:0] a;
        logic [63:0] b;
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
        return mk(fu_op_t'(4'($urandom_range(0, 6))), a, b, id);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against model, advance model, step clock
    task automatic cycle(input logic v, input fu_data_t d, input logic wr,
                         input logic fl, input logic rs, output logic accepted);
        logic     e_valid;
        logic     e_ready;
        exp_t     head;
        fu_data_t e_drive;
        issue_valid_i   = v;
        issue_fu_data_i = d;
        wb_ready_i      = wr;
        flush_i         = fl;
        rst_i           = rs;
        #2;
        e_valid = (q.size() != 0);
        head    = e_valid ? q[0] : '0;
        e_ready = (q.size() < DEPTH) || (e_valid && wr);
        e_drive = v ? d : '0;
        chk("issue_ready", 256'(issue_ready_o), 256'(e_ready));
        chk("wb_valid", 256'(wb_valid_o), 256'(e_valid));
        chk("wb_result", 256'(wb_result_o), 256'(head.res));
        chk("wb_branch", 256'(wb_branch_res_o), 256'(head.br));
        chk("wb_trans_id", 256'(wb_trans_id_o), 256'(head.id));
        chk("count", 256'(count_o), 256'(q.size()));
        chk("alu_drive", 256'(alu_fu_data_o), 256'(e_drive));
        accepted = v && e_ready && !fl && !rs;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (e_valid && wr) void'(q.pop_front());
            if (accepted) q.push_back(ref_alu(d));
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fu_data_t idle;
        fu_data_t held;
        int       n_acc;
        int       n_cyc;
        int       n_pop;
        logic     pend;
        logic [2:0] nid;

        idle            = '0;
        rst_i           = 1'b1;
        flush_i         = 1'b0;
        issue_valid_i   = 1'b0;
        issue_fu_data_i = '0;
        wb_ready_i      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset state and single op
        cycle(1'b1, mk(ALU_ADD, 64'd5, 64'd7, 3'd3), 1'b1, 1'b0, 1'b0, acc);
        chk("single_valid", 256'(wb_valid_o), 256'(1));
        chk("single_result", 256'(wb_result_o), 256'(12));
        chk("single_id", 256'(wb_trans_id_o), 256'(3));
        chk("single_count", 256'(count_o), 256'(1));
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        chk("single_drain", 256'(count_o), 256'(0));

        // Back-pressure fill and held refused op
        cycle(1'b1, mk(ALU_ADD, 64'd1, 64'd1, 3'd1), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(ALU_SUB, 64'd9, 64'd4, 3'd2), 1'b0, 1'b0, 1'b0, acc);
        held = mk(ALU_XOR, 64'hF0, 64'h0F, 3'd4);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, held, 1'b0, 1'b0, 1'b0, acc);
            chk("full_refuse", 256'(acc), 256'(0));
            chk("full_hold_id", 256'(wb_trans_id_o), 256'(1));
            chk("full_hold_res", 256'(wb_result_o), 256'(2));
        end
        cycle(1'b0, held, 1'b0, 1'b0, 1'b0, acc);

        // Full with simultaneous push and pop
        cycle(1'b1, mk(ALU_OR, 64'h30, 64'h05, 3'd5), 1'b1, 1'b0, 1'b0, acc);
        chk("pushpop_acc", 256'(acc), 256'(1));
        chk("pushpop_count", 256'(count_o), 256'(2));
        chk("pushpop_head", 256'(wb_trans_id_o), 256'(2));
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        chk("pushpop_next", 256'(wb_trans_id_o), 256'(5));
        chk("pushpop_next_res", 256'(wb_result_o), 256'(64'h35));
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

        // Branch propagation
        cycle(1'b1, mk(ALU_EQ, 64'h10, 64'h10, 3'd6), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(ALU_NE, 64'h10, 64'h10, 3'd7), 1'b0, 1'b0, 1'b0, acc);
        chk("branch_first", 256'(wb_branch_res_o), 256'(1));
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        chk("branch_second", 256'(wb_branch_res_o), 256'(0));
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

        // Flush with both handshakes active
        cycle(1'b1, mk(ALU_ADD, 64'd2, 64'd3, 3'd0), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(ALU_ADD, 64'd4, 64'd3, 3'd1), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, mk(ALU_ADD, 64'd8, 64'd8, 3'd2), 1'b1, 1'b1, 1'b0, acc);
        chk("flush_count", 256'(count_o), 256'(0));
        chk("flush_valid", 256'(wb_valid_o), 256'(0));
        cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

        // Randomized stream: reset after five accepted ops, then many wraps
        n_acc = 0;
        n_cyc = 0;
        n_pop = 0;
        nid   = 3'd0;
        pend  = 1'b0;
        held  = idle;
        while (n_acc < 45 && n_cyc < 3000) begin
            logic v;
            logic wr;
            logic popped;
            n_cyc++;
            if (!pend) begin
                held = rnd_op(nid);
                v    = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1'b1;
            end
            wr     = ($urandom_range(0, 2) != 0);
            popped = wb_valid_o && wr;
            if (n_acc == 5) begin
                cycle(v, held, wr, 1'b0, 1'b1, acc);
                chk("rst_valid", 256'(wb_valid_o), 256'(0));
                chk("rst_count", 256'(count_o), 256'(0));
                chk("rst_result", 256'(wb_result_o), 256'(0));
                chk("rst_branch", 256'(wb_branch_res_o), 256'(0));
                chk("rst_id", 256'(wb_trans_id_o), 256'(0));
                n_acc++;
                pend = 1'b0;
            end else begin
                cycle(v, held, wr, 1'b0, 1'b0, acc);
                if (popped) n_pop++;
                if (acc) begin
                    n_acc++;
                    nid  = nid + 3'd1;
                    pend = 1'b0;
                end else begin
                    pend = v;
                end
            end
        end
        chk("rand_budget", 256'(n_acc >= 45), 256'(1));
        chk("rand_wraps", 256'(n_pop >= 6), 256'(1));
        n_cyc = 0;
        while (q.size() != 0 && n_cyc < 20) begin
            n_cyc++;
            cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
        end
        chk("final_empty", 256'(count_o), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
